ex_mem_stage_reg: RTL and testbench

- EX/MEM pipeline register of the 64-bit RISC-V pipeline; sits directly downstream of the ALU and captures its result each cycle.
- Derives the registered zero, overflow and set-less-than flags from the ALU outputs and operand sign bits, so the MEM stage sees stable flags.
- Adds stall/flush control and two event counters: accepted instructions and signed overflows.

---
 rtl/ex_mem_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: captures the ALU result, derives registered
// zero/overflow/SLT flags, and keeps accepted-instruction and overflow counts.
module ex_mem_stage_reg #(
    parameter int N     = 64,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [N-1:0]     ex_alu_out,
    input  logic [3:0]       ex_operation,
    input  logic             ex_a_msb,
    input  logic             ex_b_msb,
    input  logic [N-1:0]     ex_store_data,
    input  logic [RD_W-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_branch,
    input  logic             clr_counters,
    output logic             mem_valid,
    output logic [N-1:0]     mem_result,
    output logic             mem_zero,
    output logic             mem_overflow,
    output logic [N-1:0]     mem_store_data,
    output logic [RD_W-1:0]  mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_branch_taken,
    output logic [CNT_W-1:0] insn_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic             is_add;
    logic             is_sub;
    logic             r_msb;
    logic             ovf;
    logic             slt;
    logic             zero;
    logic [N-1:0]     result;
    logic             accept;

    logic             valid_q;
    logic [N-1:0]     result_q;
    logic             zero_q;
    logic             ovf_q;
    logic [N-1:0]     store_q;
    logic [RD_W-1:0]  rd_q;
    logic             rw_q;
    logic             mr_q;
    logic             mw_q;
    logic             bt_q;
    logic [CNT_W-1:0] insn_q;
    logic [CNT_W-1:0] insn_d;
    logic [CNT_W-1:0] ovfc_q;
    logic [CNT_W-1:0] ovfc_d;

    always_comb begin
        is_add = (ex_operation == OP_ADD);
        is_sub = (ex_operation == OP_SUB) || (ex_operation == OP_SLT);
        r_msb  = ex_alu_out[N-1];
        zero   = (ex_alu_out == '0);
        ovf    = 1'b0;
        unique case (1'b1)
            is_add:  ovf = (ex_a_msb == ex_b_msb) && (r_msb != ex_a_msb);
            is_sub:  ovf = (ex_a_msb != ex_b_msb) && (r_msb != ex_a_msb);
            default: ovf = 1'b0;
        endcase
        slt    = r_msb ^ ovf;
        result = ex_alu_out;
        if (ex_operation == OP_SLT) begin
            result = {{(N-1){1'b0}}, slt};
        end
    end

    assign accept = ex_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
        end else if (!stall) begin
            valid_q  <= ex_valid;
            result_q <= result;
            zero_q   <= zero;
            ovf_q    <= ovf && ex_valid;
            store_q  <= ex_store_data;
            rd_q     <= ex_rd;
            rw_q     <= ex_reg_write && ex_valid;
            mr_q     <= ex_mem_read && ex_valid;
            mw_q     <= ex_mem_write && ex_valid;
            bt_q     <= ex_branch && zero && ex_valid;
        end
    end

    // insn_count wraps; ovf_count saturates at all-ones
    always_comb begin
        insn_d = insn_q;
        ovfc_d = ovfc_q;
        if (clr_counters) begin
            insn_d = '0;
            ovfc_d = '0;
        end else if (accept) begin
            insn_d = insn_q + CNT_W'(1);
            if (ovf && !(&ovfc_q)) begin
                ovfc_d = ovfc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_q <= '0;
            ovfc_q <= '0;
        end else begin
            insn_q <= insn_d;
            ovfc_q <= ovfc_d;
        end
    end

    assign mem_valid        = valid_q;
    assign mem_result       = result_q;
    assign mem_zero         = zero_q;
    assign mem_overflow     = ovf_q;
    assign mem_store_data   = store_q;
    assign mem_rd           = rd_q;
    assign mem_reg_write    = rw_q;
    assign mem_mem_read     = mr_q;
    assign mem_mem_write    = mw_q;
    assign mem_branch_taken = bt_q;
    assign insn_count       = insn_q;
    assign ovf_count        = ovfc_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg; narrow counters so saturation
// and wrap are reachable in a few cycles.
module tb_ex_mem_stage_reg;

    localparam int N     = 64;
    localparam int RD_W  = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [N-1:0]     ex_alu_out;
    logic [3:0]       ex_operation;
    logic             ex_a_msb;
    logic             ex_b_msb;
    logic [N-1:0]     ex_store_data;
    logic [RD_W-1:0]  ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_branch;
    logic             clr_counters;
    logic             mem_valid;
    logic [N-1:0]     mem_result;
    logic             mem_zero;
    logic             mem_overflow;
    logic [N-1:0]     mem_store_data;
    logic [RD_W-1:0]  mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             mem_branch_taken;
    logic [CNT_W-1:0] insn_count;
    logic [CNT_W-1:0] ovf_count;

    int n_cmp;
    int n_err;

    ex_mem_stage_reg #(.N(N), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .ex_alu_out       (ex_alu_out),
        .ex_operation     (ex_operation),
        .ex_a_msb         (ex_a_msb),
        .ex_b_msb         (ex_b_msb),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_branch        (ex_branch),
        .clr_counters     (clr_counters),
        .mem_valid        (mem_valid),
        .mem_result       (mem_result),
        .mem_zero         (mem_zero),
        .mem_overflow     (mem_overflow),
        .mem_store_data   (mem_store_data),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_branch_taken (mem_branch_taken),
        .insn_count       (insn_count),
        .ovf_count        (ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [3:0] op, input logic a, input logic b,
                          input logic [N-1:0] alu, input logic v);
        ex_operation = op;
        ex_a_msb     = a;
        ex_b_msb     = b;
        ex_alu_out   = alu;
        ex_valid     = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd0);
        chk({tag, ".result"}, mem_result, 64'd0);
        chk({tag, ".store"}, mem_store_data, 64'd0);
        chk({tag, ".rd"}, 64'(mem_rd), 64'd0);
        chk({tag, ".ctrl"}, 64'({mem_zero, mem_overflow, mem_reg_write,
            mem_mem_read, mem_mem_write, mem_branch_taken}), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        clr_counters  = 1'b0;
        ex_store_data = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_branch     = 1'b0;
        set_ex(4'b0000, 1'b0, 1'b0, '0, 1'b0);

        #3;
        chk_all_zero("rst");
        chk("rst.insn", 64'(insn_count), 64'd0);
        chk("rst.ovfc", 64'(ovf_count), 64'd0);

        // ADD overflow: 0x7FFF..F + 1
        set_ex(4'b0010, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
        ex_rd = 5'd5;
        ex_reg_write = 1'b1;
        ex_store_data = 64'h0000_0000_0000_1234;
        #9 rst_n = 1'b1;
        tick();
        chk("add.result", mem_result, 64'h8000_0000_0000_0000);
        chk("add.ovf", 64'(mem_overflow), 64'd1);
        chk("add.zero", 64'(mem_zero), 64'd0);
        chk("add.valid", 64'(mem_valid), 64'd1);
        chk("add.rd", 64'(mem_rd), 64'd5);
        chk("add.rw", 64'(mem_reg_write), 64'd1);
        chk("add.store", mem_store_data, 64'h1234);
        chk("add.insn", 64'(insn_count), 64'd1);
        chk("add.ovfc", 64'(ovf_count), 64'd1);

        // SLT 12 < 13
        set_ex(4'b0111, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        ex_reg_write = 1'b0;
        tick();
        chk("slt.result", mem_result, 64'd1);
        chk("slt.ovf", 64'(mem_overflow), 64'd0);
        chk("slt.insn", 64'(insn_count), 64'd2);
        chk("slt.ovfc", 64'(ovf_count), 64'd1);

        // SLT with overflow: MIN - 1
        set_ex(4'b0111, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        tick();
        chk("sltovf.result", mem_result, 64'd1);
        chk("sltovf.ovf", 64'(mem_overflow), 64'd1);
        chk("sltovf.ovfc", 64'(ovf_count), 64'd2);

        // SUB equal operands, branch
        set_ex(4'b0110, 1'b1, 1'b1, 64'd0, 1'b1);
        ex_branch = 1'b1;
        ex_mem_write = 1'b1;
        tick();
        chk("beq.zero", 64'(mem_zero), 64'd1);
        chk("beq.taken", 64'(mem_branch_taken), 64'd1);
        chk("beq.mw", 64'(mem_mem_write), 64'd1);
        chk("beq.ovf", 64'(mem_overflow), 64'd0);
        chk("beq.insn", 64'(insn_count), 64'd4);

        // same, invalid: bubble
        ex_valid = 1'b0;
        tick();
        chk("bub.taken", 64'(mem_branch_taken), 64'd0);
        chk("bub.valid", 64'(mem_valid), 64'd0);
        chk("bub.mw", 64'(mem_mem_write), 64'd0);
        chk("bub.zero", 64'(mem_zero), 64'd1);
        chk("bub.insn", 64'(insn_count), 64'd4);

        // load X then stall
        set_ex(4'b0000, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b1);
        ex_branch = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd = 5'd17;
        ex_store_data = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        chk("ldx.result", mem_result, 64'hDEAD_BEEF_0123_4567);
        chk("ldx.insn", 64'(insn_count), 64'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(4'b0010, 1'b0, 1'b0, 64'h8000_0000_0000_0000 + 64'(i), 1'b1);
            ex_rd = 5'(i + 1);
            ex_mem_read = 1'b0;
            ex_store_data = 64'(i);
            tick();
            chk("stl.result", mem_result, 64'hDEAD_BEEF_0123_4567);
            chk("stl.rd", 64'(mem_rd), 64'd17);
            chk("stl.mr", 64'(mem_mem_read), 64'd1);
            chk("stl.store", mem_store_data, 64'hA5A5_A5A5_A5A5_A5A5);
            chk("stl.insn", 64'(insn_count), 64'd5);
            chk("stl.ovfc", 64'(ovf_count), 64'd2);
        end

        // stall + flush together
        flush = 1'b1;
        tick();
        chk_all_zero("sflush");
        chk("sflush.insn", 64'(insn_count), 64'd5);
        stall = 1'b0;
        flush = 1'b0;

        // NOR never overflows
        set_ex(4'b1100, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
        tick();
        chk("nor.ovf", 64'(mem_overflow), 64'd0);
        chk("nor.insn", 64'(insn_count), 64'd6);
        chk("nor.ovfc", 64'(ovf_count), 64'd2);

        // 13 overflowing ADDs bring ovf_count to 15
        set_ex(4'b0010, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
        for (int i = 0; i < 13; i++) tick();
        chk("sat.ovfc", 64'(ovf_count), 64'd15);
        chk("wrap.insn", 64'(insn_count), 64'd3);
        tick();
        chk("sat2.ovfc", 64'(ovf_count), 64'd15);
        chk("sat2.insn", 64'(insn_count), 64'd4);

        // clear wins over accept
        clr_counters = 1'b1;
        tick();
        chk("clr.insn", 64'(insn_count), 64'd0);
        chk("clr.ovfc", 64'(ovf_count), 64'd0);
        chk("clr.valid", 64'(mem_valid), 64'd1);
        clr_counters = 1'b0;
        tick();
        chk("post.insn", 64'(insn_count), 64'd1);
        chk("post.ovfc", 64'(ovf_count), 64'd1);

        // asynchronous reset mid-cycle during a stall
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        chk("arst.insn", 64'(insn_count), 64'd0);
        chk("arst.ovfc", 64'(ovf_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        set_ex(4'b0001, 1'b0, 1'b0, 64'h55, 1'b1);
        tick();
        chk("resume.result", mem_result, 64'h55);
        chk("resume.valid", 64'(mem_valid), 64'd1);
        chk("resume.insn", 64'(insn_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
